kronos_wb_arbiter: RTL and testbench
====================================

// Module: kronos_wb_arbiter
// PURPOSE
//  Schedules the single register-file write port between three writeback requesters:
//  ALU result (EX), load data (LSU) and CSR read data (CSR unit).
//  Fixed priority LSU > CSR > ALU, with per-requester aging so no source starves.
//  Drives the registered regwr_* bus consumed by the register file and by decode forwarding.
//  Drives regwr_pending, which decode uses for hazard stalls.
// PARAMETERS
//  STARVE_LIMIT  4  cycles a valid requester may be refused before it is forced to top priority; 0 disables aging
// PORTS
//  clk           in   1   core clock
//  rst           in   1   reset, asynchronous, active-high
//  alu_vld       in   1   ALU writeback request
//  alu_rdy       out  1   ALU request granted this cycle
//  alu_sel       in   5   ALU destination register
//  alu_data      in   32  ALU writeback data
//  lsu_vld/rdy/sel/data   same as alu_*, load writeback
//  csr_vld/rdy/sel/data   same as alu_*, CSR read-data writeback
//  regwr_en      out  1   register write strobe (registered)
//  regwr_sel     out  5   register write index (registered)
//  regwr_data    out  32  register write data (registered)
//  regwr_pending out  1   any writeback request outstanding (combinational)
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - regwr_en=0, regwr_sel=0, regwr_data=0, all age counters=0.
//    - *_rdy=0 and regwr_pending=0 while rst=1.
//  - Handshake: a transfer occurs when vld&rdy. Requester holds vld/sel/data stable until its rdy.
//    - At most one rdy is high per cycle.
//    - rdy is never high without the matching vld.
//    - rdy is combinational from vld and age state. There is no vld->rdy->vld loop.
//  - Arbitration, each cycle, among valid requesters:
//    1. Any requester whose age == STARVE_LIMIT (STARVE_LIMIT>0) wins. Ties go to LSU > CSR > ALU.
//    2. Otherwise the winner is LSU > CSR > ALU.
//  - Latency: a grant in cycle N gives regwr_en=1 with that sel/data in cycle N+1.
//    - Throughput is one write per cycle.
//    - regwr_en is high for exactly one cycle per transfer.
//  - x0 filtering: a granted request with sel==0 completes (rdy=1).
//    - regwr_en stays 0 the next cycle.
//    - regwr_sel and regwr_data hold their previous values.
//  - Idle: with no grant, regwr_en=0 next cycle; sel/data hold their previous values.
//  - Age counters, width $clog2(STARVE_LIMIT+1):
//    - vld & ~rdy: increment, saturating at STARVE_LIMIT.
//    - rdy, or ~vld: clear to 0.
//  - regwr_pending = alu_vld | lsu_vld | csr_vld (vld with sel==0 included).
//    - regwr_pending is independent of the output register.
//  - Ordering: producers (via hazard control) guarantee no two concurrent requests share a nonzero sel.
//    - The arbiter does not reorder-check.
//    - The bench asserts the guarantee.
//  - Reset mid-stream: a grant taken in the reset-release cycle is allowed.
//    - Any grant pending at rst assertion is lost.
//    - The requester must re-present the request.
// STRUCTURE
//  - kronos_types gains:
//    - typedef struct packed {logic [4:0] sel; logic [31:0] data;} wbreq_t
//    - enum WB_LSU=0, WB_CSR=1, WB_ALU=2 (priority index)
//  - Sub-module kronos_wb_pick is combinational.
//    - In: 3 vld bits and 3 "aged" bits.
//    - Out: one-hot grant.
//  - The top level holds the age counters, output register and muxes.
// TESTING
//  1. ALU only: alu_vld=1, sel=5, data=0xDEADBEEF
//     -> alu_rdy=1 in cycle 0
//     -> cycle 1: regwr_en=1, regwr_sel=5, regwr_data=0xDEADBEEF
//     -> cycle 2: regwr_en=0.
//  2. All three valid in the same cycle, held until granted (lsu sel=1, csr sel=2, alu sel=3)
//     -> grants in order LSU, CSR, ALU on cycles 0, 1, 2
//     -> regwr_sel = 1, 2, 3 on cycles 1, 2, 3
//     -> regwr_pending drops in cycle 3.
//  3. Starvation, STARVE_LIMIT=4: ALU held valid while LSU/CSR present a new request every cycle
//     -> ALU refused cycles 0..3
//     -> alu_rdy=1 in cycle 4
//     -> ALU age reads 0 in cycle 5.
//  4. x0 write: csr_vld=1, sel=0, data=0x1234
//     -> csr_rdy=1
//     -> next cycle regwr_en=0 and regwr_data unchanged.
//  5. Reset mid-stream: assert rst mid-cycle while lsu_vld=1
//     -> regwr_en, regwr_sel, regwr_data go to 0 immediately, without waiting for clk
//     -> lsu_rdy=0
//     -> after release, with the request re-presented: granted the next cycle, age starts at 0.
//  6. STARVE_LIMIT=0: ALU held against continuous LSU traffic for 20 cycles
//     -> alu_rdy=0 throughout
//     -> no regwr_en cycle carries alu_sel.

Source files
------------

// File: rtl/kronos_types.sv
// Shared writeback types: request payload, requester priority index and a
// lowest-index-wins helper used by the grant picker.
package kronos_types;

  localparam int NUM_WB = 3;

  // Index doubles as fixed priority: lower index wins.
  typedef enum logic [1:0] {
    WB_LSU = 2'd0,
    WB_CSR = 2'd1,
    WB_ALU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } wbreq_t;

  // One-hot of the lowest set bit (highest priority requester).
  function automatic logic [NUM_WB-1:0] first_one(input logic [NUM_WB-1:0] v);
    logic [NUM_WB-1:0] r;
    r = '0;
    for (int i = NUM_WB-1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/kronos_wb_pick.sv
// Combinational writeback grant picker. Starved requesters pre-empt the
// fixed order; within either class the lowest index wins.
module kronos_wb_pick
  import kronos_types::*;
(
  input  logic [NUM_WB-1:0] vld,
  input  logic [NUM_WB-1:0] aged,
  output logic [NUM_WB-1:0] gnt
);

  logic [NUM_WB-1:0] starved;

  assign starved = vld & aged;

  // Aged requesters take precedence over the plain priority order.
  always_comb begin
    gnt = '0;
    if (|starved) gnt = first_one(starved);
    else          gnt = first_one(vld);
  end

endmodule

// File: rtl/kronos_wb_arbiter.sv
// Register-file write port arbiter: LSU > CSR > ALU with per-requester aging,
// registered regwr_* output bus and combinational regwr_pending for decode.
module kronos_wb_arbiter
  import kronos_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_vld,
  output logic        alu_rdy,
  input  logic [4:0]  alu_sel,
  input  logic [31:0] alu_data,
  input  logic        lsu_vld,
  output logic        lsu_rdy,
  input  logic [4:0]  lsu_sel,
  input  logic [31:0] lsu_data,
  input  logic        csr_vld,
  output logic        csr_rdy,
  input  logic [4:0]  csr_sel,
  input  logic [31:0] csr_data,
  output logic        regwr_en,
  output logic [4:0]  regwr_sel,
  output logic [31:0] regwr_data,
  output logic        regwr_pending
);

  // A zero limit still needs a 1-bit counter; it simply never leaves 0.
  localparam int            AW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT+1) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

  logic   [NUM_WB-1:0]         vld, aged, gnt, rdy;
  logic   [NUM_WB-1:0][AW-1:0] age;
  wbreq_t [NUM_WB-1:0]         req;
  wbreq_t                      win;
  logic                        take;

  assign vld         = {alu_vld, csr_vld, lsu_vld};
  assign req[WB_LSU] = '{sel: lsu_sel, data: lsu_data};
  assign req[WB_CSR] = '{sel: csr_sel, data: csr_data};
  assign req[WB_ALU] = '{sel: alu_sel, data: alu_data};

  for (genvar i = 0; i < NUM_WB; i++) begin : g_aged
    assign aged[i] = (STARVE_LIMIT > 0) && (age[i] == AGE_MAX);
  end

  kronos_wb_pick u_pick (
    .vld  (vld),
    .aged (aged),
    .gnt  (gnt)
  );

  // Grants are squashed while reset is held so nothing is acknowledged then.
  assign rdy     = gnt & {NUM_WB{~rst}};
  assign lsu_rdy = rdy[WB_LSU];
  assign csr_rdy = rdy[WB_CSR];
  assign alu_rdy = rdy[WB_ALU];

  assign regwr_pending = (|vld) & ~rst;

  // Payload of the granted requester (gnt is one-hot).
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_WB; i++)
      if (gnt[i]) win = req[i];
  end

  // x0 writes complete the handshake but never strobe the register file.
  assign take = (|rdy) && (win.sel != 5'd0);

  // Age counters: count refusals, saturate at the limit, clear on grant or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (vld[i] && !rdy[i]) begin
          if (age[i] != AGE_MAX) age[i] <= age[i] + AW'(1);
        end else begin
          age[i] <= '0;
        end
      end
    end
  end

  // Output register: one-cycle strobe, sel/data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_en   <= 1'b0;
      regwr_sel  <= '0;
      regwr_data <= '0;
    end else begin
      regwr_en <= take;
      if (take) begin
        regwr_sel  <= win.sel;
        regwr_data <= win.data;
      end
    end
  end

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
// Bench for kronos_wb_arbiter: two instances (aging limit 4 and aging off)
// driven by held-until-granted requesters and scored against a cycle model.
module tb_kronos_wb_arbiter;
  import kronos_types::*;

  logic gclk_unused;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index d: 0 -> STARVE_LIMIT=4, 1 -> STARVE_LIMIT=0. Source s: 0 LSU, 1 CSR, 2 ALU.
  logic [1:0][2:0]       vld;
  logic [1:0][2:0][4:0]  sel;
  logic [1:0][2:0][31:0] dat;
  wire  [1:0][2:0]       rdy;
  wire  [1:0]            en, pend;
  wire  [1:0][4:0]       osel;
  wire  [1:0][31:0]      odat;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    kronos_wb_arbiter #(.STARVE_LIMIT(d == 0 ? 4 : 0)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .alu_vld       (vld[d][2]),
      .alu_rdy       (rdy[d][2]),
      .alu_sel       (sel[d][2]),
      .alu_data      (dat[d][2]),
      .lsu_vld       (vld[d][0]),
      .lsu_rdy       (rdy[d][0]),
      .lsu_sel       (sel[d][0]),
      .lsu_data      (dat[d][0]),
      .csr_vld       (vld[d][1]),
      .csr_rdy       (rdy[d][1]),
      .csr_sel       (sel[d][1]),
      .csr_data      (dat[d][1]),
      .regwr_en      (en[d]),
      .regwr_sel     (osel[d]),
      .regwr_data    (odat[d]),
      .regwr_pending (pend[d])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int          age [2][3];
  int          win [2];
  logic        exp_en  [2];
  logic [4:0]  exp_sel [2];
  logic [31:0] exp_dat [2];

  function automatic int lim(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) age[d][s] = 0;
      exp_en[d] = 1'b0; exp_sel[d] = '0; exp_dat[d] = '0; win[d] = -1;
    end
  endtask

  // A requester refused STARVE_LIMIT times jumps the queue; else LSU>CSR>ALU.
  function automatic int pick(input int d);
    if (lim(d) > 0)
      for (int s = 0; s < 3; s++)
        if (vld[d][s] && age[d][s] >= lim(d)) return s;
    for (int s = 0; s < 3; s++)
      if (vld[d][s]) return s;
    return -1;
  endfunction

  // Combinational outputs, sampled after inputs settle and before the edge.
  task automatic settle_check();
    logic [2:0] er;
    logic       dup;
    #1;
    for (int d = 0; d < 2; d++) begin
      win[d] = pick(d);
      er = '0;
      if (win[d] >= 0) er[win[d]] = 1'b1;
      chk($sformatf("rdy%0d", d), rdy[d], er);
      chk($sformatf("pend%0d", d), pend[d], |vld[d]);
      dup = 1'b0;
      for (int a = 0; a < 3; a++)
        for (int b = a+1; b < 3; b++)
          if (vld[d][a] && vld[d][b] && sel[d][a] != 0 && sel[d][a] == sel[d][b]) dup = 1'b1;
      if (dup) chk($sformatf("uniq%0d", d), dup, 1'b0);
    end
  endtask

  // Clock edge: advance the model, check registered outputs, retire grants.
  task automatic edge_update();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++)
        if (vld[d][s] && s != win[d]) age[d][s] = (age[d][s] < lim(d)) ? age[d][s] + 1 : lim(d);
        else                          age[d][s] = 0;
      if (win[d] >= 0 && sel[d][win[d]] != 0) begin
        exp_en[d] = 1'b1; exp_sel[d] = sel[d][win[d]]; exp_dat[d] = dat[d][win[d]];
      end else begin
        exp_en[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("en%0d", d),  en[d],   exp_en[d]);
      chk($sformatf("sel%0d", d), osel[d], exp_sel[d]);
      chk($sformatf("dat%0d", d), odat[d], exp_dat[d]);
      if (win[d] >= 0) vld[d][win[d]] = 1'b0;
    end
  endtask

  task automatic step();
    settle_check();
    edge_update();
  endtask

  task automatic put(input int d, input int s, input logic [4:0] sl, input logic [31:0] dt);
    vld[d][s] = 1'b1; sel[d][s] = sl; dat[d][s] = dt;
  endtask

  // New random request with a destination not shared by another live request.
  task automatic new_req(input int d, input int s);
    logic [4:0] sl;
    logic       clash;
    sl = '0;
    if ($urandom_range(0, 4) != 0) begin
      do begin
        sl = 5'($urandom_range(1, 31));
        clash = 1'b0;
        for (int o = 0; o < 3; o++)
          if (o != s && vld[d][o] && sel[d][o] == sl) clash = 1'b1;
      end while (clash);
    end
    put(d, s, sl, $urandom);
  endtask

  task automatic randgen(input int d, input int p);
    for (int s = 0; s < 3; s++)
      if (!vld[d][s] && $urandom_range(0, 99) < p) new_req(d, s);
  endtask

  int          cnt, hits;
  logic [31:0] held;

  initial begin
    gclk_unused = 1'b0;
    vld = '0; sel = '0; dat = '0;
    rst = 1'b1;
    model_reset();

    // Reset state, and no rdy/pending while reset is held even with requests.
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_en", en[d], 1'b0);
      chk("rst_sel", osel[d], 5'd0);
      chk("rst_dat", odat[d], 32'd0);
    end
    put(0, 0, 5'd1, 32'h11); put(0, 1, 5'd2, 32'h22); put(0, 2, 5'd3, 32'h33);
    #1;
    chk("rst_rdy", rdy[0], 3'b000);
    chk("rst_pend", pend[0], 1'b0);
    vld = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ALU alone: grant now, write next cycle, strobe gone the cycle after.
    put(0, 2, 5'd5, 32'hDEADBEEF);
    step();
    chk("t1_sel", osel[0], 5'd5);
    chk("t1_dat", odat[0], 32'hDEADBEEF);
    step();
    chk("t1_en_off", en[0], 1'b0);

    // Three simultaneous requests drain in priority order.
    put(0, 0, 5'd1, 32'hA1); put(0, 1, 5'd2, 32'hA2); put(0, 2, 5'd3, 32'hA3);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t2_order", osel[0], 5'(k));
    end
    settle_check();
    chk("t2_pend", pend[0], 1'b0);
    edge_update();

    // Starvation: ALU held against continuous LSU traffic, twice in a row so
    // the second wait shows the age restarting from zero after the grant.
    for (int round = 0; round < 2; round++) begin
      put(0, 2, 5'd7, 32'h700 + 32'(round));
      cnt = -1;
      for (int c = 0; c < 10 && cnt < 0; c++) begin
        if (!vld[0][0]) put(0, 0, 5'd10, $urandom);
        #1;
        if (rdy[0][2]) cnt = c;
        step();
      end
      chk("t3_starve", 32'(cnt), 32'd4);
    end
    vld[0] = '0;
    step();

    // x0 write completes but does not strobe or disturb the held data.
    held = odat[0];
    put(0, 1, 5'd0, 32'h1234);
    settle_check();
    chk("t4_rdy", rdy[0][1], 1'b1);
    edge_update();
    chk("t4_en", en[0], 1'b0);
    chk("t4_dat", odat[0], held);

    // Asynchronous reset mid-cycle drops the pending LSU grant.
    put(0, 0, 5'd9, 32'h99);
    settle_check();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_en", en[0], 1'b0);
    chk("t5_sel", osel[0], 5'd0);
    chk("t5_dat", odat[0], 32'd0);
    chk("t5_rdy", rdy[0][0], 1'b0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    settle_check();
    chk("t5_regrant", rdy[0][0], 1'b1);
    edge_update();
    chk("t5_sel9", osel[1 - 1], 5'd9);

    // Aging disabled: ALU never wins against constant LSU traffic.
    put(1, 2, 5'd4, 32'h44);
    cnt = 0; hits = 0;
    for (int c = 0; c < 20; c++) begin
      if (!vld[1][0]) put(1, 0, 5'd6, $urandom);
      #1;
      if (rdy[1][2]) cnt++;
      step();
      if (en[1] && osel[1] == 5'd4) hits++;
    end
    chk("t6_alu_rdy", 32'(cnt), 32'd0);
    chk("t6_alu_wr", 32'(hits), 32'd0);
    vld = '0;
    step();

    // Random traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      randgen(0, 45);
      randgen(1, 45);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop so a wedged run still reports.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
